ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 107 ++++++++++
 tb/tb_ram_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter sharing one single-port RAM via an IDLE/ACCESS/RESP FSM.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins ties.
module ram_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  logic   grant;
  logic   pick;
  logic   wr_q;
  logic   ack0_q;
  logic   ack1_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic last;

  always_comb begin
    pick = ~req0;
    if (req0 && req1) pick = ~last;
  end

  always_ff @(posedge clk) begin
    if (rst) last <= 1'b1;
    else if (state == IDLE && (req0 || req1)) last <= pick;
  end
`else
  always_comb pick = ~req0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      wr_q        <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (req0 || req1) begin
            grant       <= pick;
            wr_q        <= pick ? we1 : we0;
            ram_addr    <= pick ? addr1 : addr0;
            ram_wr_data <= pick ? wdata1 : wdata0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          wr_q <= 1'b0;
          if (!wr_q) begin
            if (grant) rdata1 <= ram_rd_data;
            else       rdata0 <= ram_rd_data;
          end
          ack0_q <= ~grant;
          ack1_q <= grant;
          state  <= RESP;
        end
        RESP: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gate with rst so an aborted ACCESS never strobes and an aborted RESP never acks.
  assign ram_wr = wr_q & ~rst;
  assign ack0   = ack0_q & ~rst;
  assign ack1   = ack1_q & ~rst;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter with a transaction-level reference model.
// Build with or without ARB_ROUND_ROBIN_EN; the model follows the same macro.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, ram_wr;
  logic [7:0] rdata0, rdata1;
  logic [2:0] ram_addr;
  logic [7:0] ram_wr_data, ram_rd_data;

  logic [7:0] mem [8];

  int errs   = 0;
  int checks = 0;

  logic [7:0] mem_m [8];
  logic [7:0] rd_m  [2];
  bit         last_m;

  ram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .busy       (busy),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_pick(bit r0, bit r1);
`ifdef ARB_ROUND_ROBIN_EN
    if (r0 && r1) return !last_m;
`endif
    return !r0;
  endfunction

  task automatic model_reset();
    rd_m[0] = '0;
    rd_m[1] = '0;
    last_m  = 1'b1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_wr", ram_wr, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wr_data, 0);
    chk("rst_rd0", rdata0, 0);
    chk("rst_rd1", rdata1, 0);
    tick();
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [2:0] a0, input logic [2:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input bit scr, output bit seen);
    bit         win, cw;
    logic [2:0] ca;
    logic [7:0] cd;
    seen = 1'b0;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ack", {ack0, ack1}, 0);
    if (!r0 && !r1) begin
      tick();
      return;
    end
    win = model_pick(r0, r1);
    last_m = win;
    cw = win ? w1 : w0;
    ca = win ? a1 : a0;
    cd = win ? d1 : d0;
    tick();
    if (scr) begin
      req0 = 1'($urandom); req1 = 1'($urandom);
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = 3'($urandom); addr1 = 3'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
    end
    @(negedge clk);
    chk("acc_wr", ram_wr, cw);
    chk("acc_addr", ram_addr, ca);
    chk("acc_wdata", ram_wr_data, cd);
    chk("acc_busy", busy, 1);
    chk("acc_ack", {ack0, ack1}, 0);
    if (cw) mem_m[ca] = cd;
    else    rd_m[win] = mem_m[ca];
    tick();
    @(negedge clk);
    chk("resp_ack0", ack0, !win);
    chk("resp_ack1", ack1, win);
    chk("resp_wr", ram_wr, 0);
    chk("resp_busy", busy, 1);
    chk("resp_addr", ram_addr, ca);
    chk("resp_wdata", ram_wr_data, cd);
    chk("resp_rd0", rdata0, rd_m[0]);
    chk("resp_rd1", rdata1, rd_m[1]);
    seen = ack1;
    tick();
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 8; i++) begin
      mem[i]   = '0;
      mem_m[i] = '0;
    end
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    do_reset();

    // Write CC to addr 0 from requester 0, read it back via requester 1.
    run_txn(1, 0, 1, 0, 3'd0, 3'd5, 8'hCC, 8'h11, 0, seen);
    run_txn(0, 1, 0, 0, 3'd4, 3'd0, 8'h22, 8'h33, 0, seen);
    chk("rd1_cc", rdata1, 8'hCC);
    chk("rd0_hold", rdata0, 0);

    // Reset lands on the ACCESS edge of a write of 55 to addr 3.
    do_reset();
    req0 = 1; we0 = 1; addr0 = 3'd3; wdata0 = 8'h55; req1 = 0;
    tick();
    req0 = 0;
    rst = 1'b1;
    #1;
    chk("abort_wr", ram_wr, 0);
    chk("abort_ack", {ack0, ack1}, 0);
    tick();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_noack", {ack0, ack1}, 0);
    tick();
    @(negedge clk);
    chk("abort_noack2", {ack0, ack1}, 0);
    tick();
    run_txn(0, 1, 0, 0, 3'd0, 3'd3, 8'h00, 8'h00, 0, seen);
    chk("abort_rd_not55", (rdata1 == 8'h55), 0);

    // Randomized traffic with inputs scrambled outside IDLE.
    for (int i = 0; i < 80; i++) begin
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1, seen);
    end

    // Both requesters continuously reading.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_txn(1, 1, 0, 0, 3'($urandom), 3'($urandom), 8'h00, 8'h00, 0, seen);
`ifdef ARB_ROUND_ROBIN_EN
      chk("tie_seq", seen, 1'(i % 2));
`else
      chk("tie_seq", seen, 0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
